// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// Holds FSM state codes, bus owner codes and the streak counter width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_DM   = 2'd2,
        ARB_RESP = 2'd3
    } arbState_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_DM   = 2'b10;

    // Wide enough for the largest allowed streak limit (15).
    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_streak_cnt.sv
// Saturating count of data grants made while fetch was waiting.
// Ports: clk, rst (sync, active-low), inc, clr, count, sat (count == MAX).
module arb_streak_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STREAK_W-1:0] count,
    output logic                sat
);

    assign sat = (count == STREAK_W'(MAX));

    // Clear wins over increment; increment stops at MAX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports.
// Ports: if_* fetch port, dm_* data port, mem_* memory bus, owner debug.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner
);

    arbState_t            state;
    logic                 grantDm;
    logic                 grantIf;
    logic                 streakInc;
    logic                 streakClr;
    logic                 streakSat;
    logic [STREAK_W-1:0]  streakCount;

    // Data wins unless fetch is waiting and the streak limit is reached.
    always_comb begin
        grantDm = (state == ARB_IDLE) && dm_req
                  && (!if_req || !streakSat);
        grantIf = (state == ARB_IDLE) && if_req && !grantDm;
    end

    // Streak only grows while fetch is actually being passed over.
    always_comb begin
        streakInc = grantDm && if_req;
        streakClr = grantIf || (grantDm && !if_req);
    end

    arb_streak_cnt #(
        .MAX   (MAX_DM_STREAK)
    ) uStreak (
        .clk   (clk),
        .rst   (rst),
        .inc   (streakInc),
        .clr   (streakClr),
        .count (streakCount),
        .sat   (streakSat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            owner     <= OWN_NONE;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    unique case (1'b1)
                        grantDm: begin
                            mem_req   <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            owner     <= OWN_DM;
                            state     <= ARB_DM;
                        end
                        grantIf: begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            owner     <= OWN_IF;
                            state     <= ARB_IF;
                        end
                        default: begin
                        end
                    endcase
                end
                ARB_IF: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= ARB_RESP;
                    end
                end
                ARB_DM: begin
                    if (mem_ready) begin
                        // Stores leave the last load value in place.
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_ack  <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    // One dead cycle so the port can retire its request.
                    owner <= OWN_NONE;
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Stimulus pushes expected grants and read data; monitors pop and compare.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [1:0]  owner;

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .MAX_DM_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  own;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    int          checks = 0;
    int          errors = 0;
    int          latency = 1;
    int          grantsSeen = 0;
    int          acksSeen = 0;
    grant_t      grantQ[$];
    logic [31:0] ifQ[$];
    logic [31:0] dmQ[$];
    logic [31:0] memModel[logic [31:0]];
    logic [31:0] refMem[logic [31:0]];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory responder: mem_ready on the latency-th mem_req cycle.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                cnt++;
                if (cnt >= latency) begin
                    mem_ready = 1'b1;
                    if (mem_we) begin
                        memModel[mem_addr] = mem_wdata;
                        mem_rdata = '0;
                    end else if (memModel.exists(mem_addr)) begin
                        mem_rdata = memModel[mem_addr];
                    end else begin
                        mem_rdata = '0;
                    end
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                cnt = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: grants, address stability, acks and invariants.
    initial begin
        logic        prevReq = 1'b0;
        logic [31:0] holdAddr = '0;
        grant_t      g;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (mem_req && !prevReq) begin
                grantsSeen++;
                if (grantQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected grant: addr %h", mem_addr);
                end else begin
                    g = grantQ.pop_front();
                    check("grant owner", 32'(owner), 32'(g.own));
                    check("grant we", 32'(mem_we), 32'(g.we));
                    check("grant addr", mem_addr, g.addr);
                    if (g.we) check("grant wdata", mem_wdata, g.wdata);
                end
                holdAddr = mem_addr;
            end else if (mem_req) begin
                check("addr stable", mem_addr, holdAddr);
            end
            prevReq = mem_req;
            if (if_ack || dm_ack) begin
                acksSeen++;
                check("dual ack", 32'(if_ack && dm_ack), 32'd0);
                check("mem_req in resp", 32'(mem_req), 32'd0);
            end
            if (if_ack) begin
                check("if owner", 32'(owner), 32'(OWN_IF));
                if (ifQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra if_ack: got 1 want 0");
                end else begin
                    e = ifQ.pop_front();
                    check("if_rdata", if_rdata, e);
                end
            end
            if (dm_ack) begin
                check("dm owner", 32'(owner), 32'(OWN_DM));
                if (dmQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra dm_ack: got 1 want 0");
                end else begin
                    e = dmQ.pop_front();
                    check("dm_rdata", dm_rdata, e);
                end
            end
        end
    end

    task automatic waitAck(bit isDm, int expLat, string name);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            got = isDm ? dm_ack : if_ack;
        end
        check({name, " ack latency"}, 32'(n), 32'(expLat));
    endtask

    task automatic expectGrant(bit isDm, bit we, logic [31:0] a,
                               logic [31:0] wd);
        grant_t g;
        g.own   = isDm ? OWN_DM : OWN_IF;
        g.we    = isDm && we;
        g.addr  = a;
        g.wdata = wd;
        grantQ.push_back(g);
    endtask

    // Called at a negedge while the arbiter is idle.
    task automatic access(bit isDm, bit we, logic [31:0] a,
                          logic [31:0] wd, logic [31:0] expData,
                          int expLat, string name);
        expectGrant(isDm, we, a, wd);
        if (isDm) begin
            dmQ.push_back(expData);
            dm_req   = 1'b1;
            dm_we    = we;
            dm_addr  = a;
            dm_wdata = wd;
        end else begin
            ifQ.push_back(expData);
            if_req  = 1'b1;
            if_addr = a;
        end
        waitAck(isDm, expLat, name);
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        check({name, " idle owner"}, 32'(owner), 32'(OWN_NONE));
        check({name, " idle mem_req"}, 32'(mem_req), 32'd0);
        check({name, " single ack"}, 32'({if_ack, dm_ack}), 32'd0);
    endtask

    initial begin
        logic [31:0] lastLoad;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] ed;
        int          acks;
        int          n;
        bit          isDm;
        bit          we;
        int          lat;

        memModel[32'h100] = 32'hCAFEF00D;
        memModel[32'h40]  = 32'hDEADBEEF;
        memModel[32'h0]   = 32'h2402000A;
        memModel[32'h8]   = 32'h0BADF00D;
        memModel[32'h200] = 32'h11111111;
        memModel[32'h300] = 32'h22222222;
        for (int i = 0; i < 8; i++) begin
            memModel[32'h1000 + 32'(4 * i)] = 32'hA5000000 + 32'(i);
            refMem[32'h1000 + 32'(4 * i)]   = 32'hA5000000 + 32'(i);
        end

        repeat (2) @(negedge clk);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst acks", 32'({if_ack, dm_ack}), 32'd0);
        check("rst owner", 32'(owner), 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        check("rst dm_rdata", dm_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a stalled fetch.
        latency = 1000;
        expectGrant(1'b0, 1'b0, 32'h100, 32'h0);
        if_req  = 1'b1;
        if_addr = 32'h100;
        @(negedge clk);
        check("midrst mem_req up", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst mem_req", 32'(mem_req), 32'd0);
        check("midrst owner", 32'(owner), 32'(OWN_NONE));
        check("midrst ack", 32'({if_ack, dm_ack}), 32'd0);
        rst = 1'b1;
        latency = 1;
        expectGrant(1'b0, 1'b0, 32'h100, 32'h0);
        ifQ.push_back(32'hCAFEF00D);
        waitAck(1'b0, 2, "refetch");
        if_req = 1'b0;
        @(negedge clk);

        // Zero-wait load, wait-state fetch, store, load-back.
        latency = 1;
        access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, "load0");
        latency = 4;
        access(1'b0, 1'b0, 32'h0, 32'h0, 32'h2402000A, 5, "fetchws");
        latency = 1;
        access(1'b1, 1'b1, 32'h8, 32'h12345678, 32'hDEADBEEF, 2, "store");
        access(1'b1, 1'b0, 32'h8, 32'h0, 32'h12345678, 2, "loadback");

        // Both ports held: DM x4 then IF, repeating.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                expectGrant(1'b1, 1'b0, 32'h300, 32'h0);
                dmQ.push_back(32'h22222222);
            end
            expectGrant(1'b0, 1'b0, 32'h200, 32'h0);
            ifQ.push_back(32'h11111111);
        end
        expectGrant(1'b1, 1'b0, 32'h300, 32'h0);
        dmQ.push_back(32'h22222222);
        if_req  = 1'b1;
        if_addr = 32'h200;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h300;
        acks = 0;
        n = 0;
        while (acks < 11 && n < 200) begin
            @(negedge clk);
            n++;
            if (if_ack || dm_ack) acks++;
        end
        check("starve acks", 32'(acks), 32'd11);
        check("starve cycles", 32'(n), 32'd32);
        if_req = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);

        // Random single accesses over a small address window.
        lastLoad = 32'h22222222;
        for (int t = 0; t < 30; t++) begin
            isDm = 1'($urandom_range(0, 1));
            we   = isDm && ($urandom_range(0, 2) == 0);
            a    = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            wd   = $urandom;
            lat  = $urandom_range(1, 3);
            latency = lat;
            if (we) begin
                ed = lastLoad;
                refMem[a] = wd;
            end else begin
                ed = refMem[a];
                if (isDm) lastLoad = ed;
            end
            access(isDm, we, a, wd, ed, lat + 1, "rand");
        end

        repeat (2) @(negedge clk);
        check("grantQ empty", 32'(grantQ.size()), 32'd0);
        check("ifQ empty", 32'(ifQ.size()), 32'd0);
        check("dmQ empty", 32'(dmQ.size()), 32'd0);
        check("ack per grant", 32'(acksSeen), 32'(grantsSeen - 1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Arbitrates between the two ports and sequences each access over a variable-latency memory bus (mem_ready handshake).
- Returns registered read data and a one-cycle ack to the winning port.
- The pipeline's hazard logic stalls F or M on req && !ack.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width
MAX_DM_STREAK, 4, consecutive data-port grants allowed while fetch waits (range 1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
if_req  in  1  fetch request; held with if_addr stable until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid when dm_ack=1 and dm_we=0
dm_ack  out  1  one-cycle completion pulse for data
mem_req  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current access this cycle
owner  out  2  00 none, 01 fetch, 10 data (current bus owner, for debug and hazard unit)

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, streak=0.
  - mem_req, mem_we, if_ack, dm_ack = 0; owner=00; all data and address outputs = 0.
  - An access in flight is abandoned: mem_req drops on the next cycle and the memory must tolerate this.
- FSM states: IDLE, IF_ACC, DM_ACC, RESP.
- IDLE, arbitration on requests sampled this cycle:
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both, streak < MAX_DM_STREAK: grant data.
  - Both, streak == MAX_DM_STREAK: grant fetch.
  - Neither: stay in IDLE.
- On a grant:
  - Latch the port's addr/we/wdata into the mem_* output registers (fetch forces mem_we=0).
  - Set mem_req=1 and owner; go to IF_ACC or DM_ACC.
  - mem_* signals are therefore registered: mem_req rises the cycle after the grant decision.
- Streak counter:
  - Data grant with if_req=1: streak += 1, saturating at MAX_DM_STREAK.
  - Data grant with if_req=0: streak = 0.
  - Fetch grant: streak = 0.
- IF_ACC / DM_ACC:
  - Hold all mem_* outputs stable.
  - When mem_ready=1: capture mem_rdata into if_rdata or dm_rdata, assert the matching ack on the next cycle, clear mem_req, go to RESP.
  - No timeout; waits indefinitely.
- RESP:
  - Ack is high for exactly this cycle; owner still shows the port; no new grant is made.
  - Next state is IDLE, owner → 00.
  - This prevents re-granting a request the port has not yet retired.
- Latency:
  - Req seen in IDLE → mem_req at +1.
  - mem_ready at cycle T → ack at T+1.
  - Zero-wait memory (mem_ready=1 during the first mem_req cycle) gives ack at +2 and a minimum 3 cycles per access.
- Store: dm_rdata is not updated (it holds its last load value); dm_ack is still pulsed.
- Read data registers hold their value between acks.
- Both acks are never high in the same cycle; mem_req is never high in IDLE or RESP.
- A port dropping req before its ack is a protocol violation: the access still completes and the ack is still pulsed.
- Simultaneous reset and mem_ready: reset wins, no ack.

Decomposition:
- Shared head.v additions: state encodings (ARB_IDLE=2'd0, ARB_IF=2'd1, ARB_DM=2'd2, ARB_RESP=2'd3) and owner codes (OWN_NONE, OWN_IF, OWN_DM).
- One sub-module, arb_streak_cnt: saturating counter with inc/clr/sat ports and parameter MAX. It holds the starvation count so it can be verified standalone.
- FSM, output registers and data capture stay in the top level.

Test Plan:
1. Reset mid-access:
   - Grant fetch at 0x100, mem_ready held 0; assert rst=0 for 1 cycle.
   - Next cycle: mem_req=0, owner=00, no ack.
   - After release, if_req still high → mem_req rises again with mem_addr=0x100.
2. Single load, zero-wait:
   - dm_req, dm_we=0, dm_addr=0x40; mem returns 0xDEADBEEF with mem_ready on its first cycle.
   - mem_req at +1; dm_ack with dm_rdata=0xDEADBEEF at +2; IDLE at +3.
3. Wait states:
   - if_req at 0x0; mem_ready asserted on the 4th mem_req cycle with 0x2402000A.
   - mem_addr stable for all 4 cycles; if_ack one cycle later with if_rdata=0x2402000A.
4. Starvation limit:
   - if_req and dm_req both held continuously, MAX_DM_STREAK=4, zero-wait memory.
   - Grant order: DM, DM, DM, DM, IF, DM…; streak resets after the IF grant.
5. Store:
   - dm_we=1, dm_addr=0x8, dm_wdata=0x12345678.
   - mem_we=1, mem_wdata=0x12345678; dm_ack pulses once; dm_rdata unchanged from the prior load.
6. Invariants, checked by assertions across random traffic:
   - Both acks never high together.
   - mem_req is never high in RESP.
   - Exactly one ack per grant.
